mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store engine in front of a single-port 32-bit RAM.
// Loads read one word and extract/extend a byte, half or word. Word stores write
// directly. Byte/half stores do read-modify-write.
// Latency from acceptance to resp_valid is 2 cycles for loads and word stores,
// and 4 cycles for sub-word stores. A trapped misaligned access takes 1 cycle.
// Backpressure: req_ready is high only in IDLE, so one access is in flight at a
// time. The response cannot be stalled.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake
//   req_we/size/signed/addr/wdata   request fields (store data right-aligned)
//   resp_valid/rdata/err     one-cycle completion; rdata/err hold until the next response
//   ram_wren/address/write_data, ram_data   RAM port (read data valid the cycle after address sample)
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// with resp_err instead of silently aligning them.

`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 16
`endif

module mem_access_unit #(
    parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write_data,
    input  logic [31:0]       ram_data
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

    state_t      state, state_nxt;

    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_hold;

    logic        accept;
    logic        misalign;
    logic        word_store;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] resp_now_rdata;
    logic [31:0] merged;

    assign accept     = (state == IDLE) && req_valid;
    assign word_store = req_we && req_size[1];

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Next-state logic and per-state strobes
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misalign)        state_nxt = RESP;
                    else if (word_store) state_nxt = WR;
                    else                 state_nxt = RD;
                end
            end
            RD:      state_nxt = we_q ? MERGE : RESP;
            MERGE:   state_nxt = WR;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign ram_wren   = (state == WR);
    assign resp_valid = (state == RESP);

    // Lane extraction. The RAM samples the address at the end of RD, so the read
    // word is on ram_data during the cycle after RD (RESP for loads, MERGE for RMW).
    always_comb begin
        byte_sel = 8'h00;
        case (lane_q)
            2'd0:    byte_sel = ram_data[7:0];
            2'd1:    byte_sel = ram_data[15:8];
            2'd2:    byte_sel = ram_data[23:16];
            default: byte_sel = ram_data[31:24];
        endcase
        half_sel = lane_q[1] ? ram_data[31:16] : ram_data[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{sgn_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{sgn_q & half_sel[15]}}, half_sel};
            default: load_ext = ram_data;
        endcase
    end

    assign resp_now_rdata = (we_q || err_q) ? 32'h0 : load_ext;

    // Read data is live only during RESP, so the output shows the extracted
    // value directly then and the captured copy afterwards.
    assign resp_rdata = (state == RESP) ? resp_now_rdata : rdata_hold;

`ifdef MISALIGN_TRAP_EN
    logic err_hold;
    assign resp_err = (state == RESP) ? err_q : err_hold;
`else
    assign resp_err = 1'b0;
`endif

    // Sub-word store: overwrite only the addressed lane(s) of the read word
    always_comb begin
        merged = ram_data;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            sgn_q          <= 1'b0;
            lane_q         <= 2'b00;
            wdata_q        <= 32'h0;
            err_q          <= 1'b0;
            rdata_hold     <= 32'h0;
            ram_address    <= '0;
            ram_write_data <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q        <= req_we;
                size_q      <= req_size;
                sgn_q       <= req_signed;
                lane_q      <= req_addr[1:0];
                wdata_q     <= req_wdata;
                err_q       <= misalign;
                ram_address <= {req_addr[ADDR_W-1:2], 2'b00};
                if (word_store && !misalign)
                    ram_write_data <= req_wdata;
            end
            if (state == MERGE)
                ram_write_data <= merged;
            if (state == RESP)
                rdata_hold <= resp_now_rdata;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 err_hold <= 1'b0;
        else if (state == RESP)  err_hold <= err_q;
    end
`endif

endmodule
